// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer.
// Stage indices follow the datapath order: load, conv1, pool1, conv2, pool2, fc.
package cnn_pkg;

  localparam int unsigned NUM_STAGES = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DRAIN_W    = 4;

  localparam logic [IDX_W-1:0] STG_LOAD   = 3'd0;
  localparam logic [IDX_W-1:0] STG_CONV1  = 3'd1;
  localparam logic [IDX_W-1:0] STG_POOL1  = 3'd2;
  localparam logic [IDX_W-1:0] STG_CONV2  = 3'd3;
  localparam logic [IDX_W-1:0] STG_POOL2  = 3'd4;
  localparam logic [IDX_W-1:0] STG_FC     = 3'd5;
  localparam logic [IDX_W-1:0] STAGE_NONE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Registered control bundle driven towards the stage address counters
  typedef struct packed {
    logic [NUM_STAGES-1:0] en;
    logic [NUM_STAGES-1:0] clr;
    logic [IDX_W-1:0]      id;
    logic                  busy;
    logic                  done;
  } seq_out_t;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [IDX_W-1:0] idx);
    stage_onehot = NUM_STAGES'(1) << idx;
  endfunction

endpackage

// File: rtl/cnn_drain_timer.sv
// Loadable 4-bit down-counter; expired_o is high while the count sits at zero.
module cnn_drain_timer
  import cnn_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               load_i,
  input  logic [DRAIN_W-1:0] load_val_i,
  output logic               expired_o
);

  logic [DRAIN_W-1:0] cnt_q, cnt_d;
  logic               expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Steps the six CNN stages through clear / run / drain and reports progress.
// Outputs are registered from the next-state decode so they line up with the state.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CYC_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [NUM_STAGES-1:0] stage_clr_o,
  output logic [IDX_W-1:0]      stage_id_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CYC_W-1:0]      run_cycles_o
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES == 0) ? DRAIN_W'(0) : DRAIN_W'(DRAIN_CYCLES - 1);

  localparam seq_out_t OUT_RST = '{en: '0, clr: '0, id: STAGE_NONE, busy: 1'b0, done: 1'b0};

  state_e           state_q, state_d;
  state_e           adv_state;
  logic [IDX_W-1:0] idx_q, idx_d, adv_idx;
  logic [CYC_W-1:0] rc_q, rc_d;
  seq_out_t         out_q, out_d;
  logic             drain_load;
  logic             drain_expired;
  logic             abort_hit;

  cnn_drain_timer u_drain_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (drain_load),
    .load_val_i (DRAIN_LOAD),
    .expired_o  (drain_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rc_d       = rc_q;
    drain_load = 1'b0;
    abort_hit  = 1'b0;
    out_d      = OUT_RST;

    // Where a finished stage goes: the next stage's clear, or FIN after fc
    adv_state = (idx_q == STG_FC) ? ST_FIN : ST_CLR;
    adv_idx   = (idx_q == STG_FC) ? idx_q : idx_q + IDX_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = ST_CLR;
          idx_d   = STG_LOAD;
          rc_d    = '0;
        end
      end
      ST_CLR: state_d = ST_RUN;
      ST_RUN: begin
        if (stage_done_i[idx_q]) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end else begin
            state_d    = ST_DRAIN;
            drain_load = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_expired) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort_i && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      abort_hit = 1'b1;
    end

    // FIN and the aborting cycle are not counted, so the value holds afterwards
    if ((state_q == ST_CLR || state_q == ST_RUN || state_q == ST_DRAIN) &&
        !abort_i && rc_q != '1) begin
      rc_d = rc_q + CYC_W'(1);
    end

    out_d.busy = (state_d != ST_IDLE);
    out_d.done = (state_d == ST_FIN);
    if (state_d == ST_RUN) out_d.en = stage_onehot(idx_d);
    if (state_d == ST_CLR) out_d.clr = stage_onehot(idx_d);
    if (state_d == ST_CLR || state_d == ST_RUN || state_d == ST_DRAIN) out_d.id = idx_d;
    if (abort_hit) out_d.clr = '1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rc_q    <= '0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rc_q    <= rc_d;
      out_q   <= out_d;
    end
  end

  assign stage_en_o   = out_q.en;
  assign stage_clr_o  = out_q.clr;
  assign stage_id_o   = out_q.id;
  assign busy_o       = out_q.busy;
  assign done_o       = out_q.done;
  assign run_cycles_o = rc_q;

endmodule
